vga_wbm_arbiter: RTL and testbench
==================================

Name: vga_wbm_arbiter

Overview:
Arbitrates the VGA core's single Wishbone master port between two fetch requesters: the video line-buffer refill engine ("vid") and the colour-lookup-table loader ("clut"). The arbiter latches the granted requester's start address and burst length, then runs an incrementing Wishbone burst on wbm_*. It forwards per-beat acks to the owner and signals completion or error. It sits between the fetch engines and the top-level wbm_adr_o/wbm_cyc_o pins.

Parameters:
STARVE_LIMIT, 4, consecutive vid grants allowed while clut_req_i is pending before clut is forced through (range 1..15)
ADR_STEP, 4, byte increment of wbm_adr_o per acked beat

Ports:
wb_clk_i  in  1  system/Wishbone clock
wb_rst_i  in  1  asynchronous, active-high reset
vid_req_i  in  1  video fetch request; held until vid_done_o
vid_adr_i  in  32  video burst start byte address; bits [1:0] ignored
vid_len_i  in  8  video burst length in beats; 0 treated as 1
vid_gnt_o  out  1  high while a video burst owns the bus
vid_ack_o  out  1  one cycle per accepted beat; wbm_dat_i is valid that cycle
vid_done_o  out  1  one-cycle pulse at end of a video burst
vid_err_o  out  1  one-cycle pulse with done if the burst ended on wbm_err_i
clut_req_i, clut_adr_i, clut_len_i, clut_gnt_o, clut_ack_o, clut_done_o, clut_err_o: same widths and meaning as the vid_* ports, for the CLUT loader
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_adr_o  out  32  Wishbone address, bits [1:0] always 0
wbm_cti_o  out  3  010 incrementing; 111 on the last beat
wbm_bte_o  out  2  constant 00 (linear)
wbm_ack_i  in  1  Wishbone ack
wbm_err_i  in  1  Wishbone error

Behaviour:
- Reset is asynchronous and active-high, one clock. While wb_rst_i is high, all outputs are 0, the state is IDLE, and starve_cnt is 0. Reset asserted mid-burst drops cyc/stb immediately. No done pulse is generated for the aborted burst.
- States:
  - IDLE: arbitrate when any request is high.
  - BURST: bus is owned.
  - DONE: one cycle, then IDLE.
- Arbitration happens in IDLE only and takes one clock:
  - Only one requester is high: grant it.
  - Both are high and starve_cnt < STARVE_LIMIT: grant vid and increment starve_cnt.
  - Both are high and starve_cnt == STARVE_LIMIT: grant clut.
  - Any clut grant clears starve_cnt.
  - A vid grant with clut_req_i low leaves starve_cnt unchanged.
- On grant (IDLE->BURST):
  - Latch owner, adr = {req_adr[31:2],2'b00}, and remaining = (len==0 ? 1 : len).
  - The owner's gnt_o rises the next cycle together with cyc/stb.
  - Latency is 1 clock from request sampled to cyc_o high.
- BURST:
  - cyc=stb=1. wbm_cti_o=111 when remaining==1, else 010.
  - On wbm_ack_i: pulse the owner's ack_o in the same cycle (combinational from wbm_ack_i, gated by owner). Then adr += ADR_STEP (32-bit wrap at 0xFFFFFFFC -> 0) and remaining -= 1.
  - Ack on the last beat -> DONE.
  - wbm_err_i (takes priority over an ack in the same cycle) -> DONE with the error flag set. That beat produces no ack_o.
- DONE:
  - cyc=stb=0 and gnt=0.
  - The owner's done_o pulses; err_o pulses too if the error flag is set.
  - Next state is IDLE.
- Requesters must drop req_i in the cycle after done_o. The earliest next grant is 2 cycles after done_o, giving at least 1 idle bus cycle between bursts.
- Changes to adr_i and len_i during BURST are ignored.
- Requests arriving during BURST or DONE wait; none are lost.
- Exactly one gnt_o is high at a time. ack_o, done_o and err_o are never asserted for the non-owner.

Test Plan:
- vid_req_i only, adr=0x1000, len=4, ack every cycle -> wbm_adr_o 0x1000,0x1004,0x1008,0x100C; cti 010,010,010,111; 4 vid_ack_o; vid_done_o 1 cycle after last ack; cyc low in DONE.
- Both requests continuously, STARVE_LIMIT=4, len=1 -> grant order vid,vid,vid,vid,clut, repeating; starve_cnt back to 0 after each clut grant.
- clut len=0 with adr=0x2003 -> single beat at 0x2000, cti 111, clut_done_o after 1 ack.
- vid len=3, wbm_err_i on beat 2 (coincident with ack) -> 1 vid_ack_o only; vid_done_o and vid_err_o pulse together; next burst's starting address is not affected.
- Burst starting at 0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- wb_rst_i asserted after the 2nd of 8 beats -> cyc/stb/gnt drop asynchronously with no done pulse; after release with vid_req_i held, a fresh burst starts from the originally latched vid_adr_i value.

Source files
------------

// File: rtl/vga_wbm_arbiter_if.sv
// Bundle of the two fetch-requester ports and the Wishbone master pins
// around the VGA bus arbiter.
// The arbiter drives the Wishbone side, so it takes the "master" modport.
// The requesters and the Wishbone slave together take the "slave" modport.
interface vga_wbm_arbiter_if;
    // video line-buffer refill requester
    logic        vid_req_i;
    logic [31:0] vid_adr_i;
    logic [7:0]  vid_len_i;
    logic        vid_gnt_o;
    logic        vid_ack_o;
    logic        vid_done_o;
    logic        vid_err_o;

    // colour-lookup-table loader
    logic        clut_req_i;
    logic [31:0] clut_adr_i;
    logic [7:0]  clut_len_i;
    logic        clut_gnt_o;
    logic        clut_ack_o;
    logic        clut_done_o;
    logic        clut_err_o;

    // Wishbone master pins
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_adr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  vid_req_i, vid_adr_i, vid_len_i,
        output vid_gnt_o, vid_ack_o, vid_done_o, vid_err_o,
        input  clut_req_i, clut_adr_i, clut_len_i,
        output clut_gnt_o, clut_ack_o, clut_done_o, clut_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_cti_o, wbm_bte_o,
        input  wbm_ack_i, wbm_err_i
    );

    modport slave (
        output vid_req_i, vid_adr_i, vid_len_i,
        input  vid_gnt_o, vid_ack_o, vid_done_o, vid_err_o,
        output clut_req_i, clut_adr_i, clut_len_i,
        input  clut_gnt_o, clut_ack_o, clut_done_o, clut_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_cti_o, wbm_bte_o,
        output wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/vga_wbm_arbiter.sv
// VGA Wishbone master arbiter.
// Shares the single Wishbone master port between the video refill engine
// (vid) and the CLUT loader (clut). Each grant runs one incrementing burst.
// vid normally wins, but clut is forced through after STARVE_LIMIT
// consecutive vid grants taken while clut was also waiting.
module vga_wbm_arbiter #(
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int ADR_STEP     = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    vga_wbm_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]  LP_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [31:0] LP_STEP  = 32'(ADR_STEP);

    state_t      r_state;
    logic [3:0]  r_starve;      // vid grants taken while clut was pending
    logic [31:0] r_adr;
    logic [7:0]  r_rem;         // beats still to be acked
    logic        r_cyc;
    logic        r_vid_gnt;
    logic        r_clut_gnt;
    logic        r_vid_done;
    logic        r_clut_done;
    logic        r_vid_err;
    logic        r_clut_err;

    logic        w_any_req;
    logic        w_grant_clut;
    logic [31:0] w_grant_adr;
    logic [7:0]  w_grant_len;
    logic [7:0]  w_grant_rem;
    logic        w_beat_ack;
    logic        w_last;
    logic        w_unused;

    // Address bits [1:0] are word-alignment don't-cares.
    assign w_unused = ^{bus.vid_adr_i[1:0], bus.clut_adr_i[1:0]};

    assign w_any_req = bus.vid_req_i | bus.clut_req_i;

    // clut wins when it is alone, or when vid has used up its starvation budget.
    // The counter never passes the limit, so >= behaves like ==.
    assign w_grant_clut = bus.clut_req_i & (~bus.vid_req_i | (r_starve >= LP_LIMIT));
    assign w_grant_adr  = w_grant_clut ? {bus.clut_adr_i[31:2], 2'b00}
                                       : {bus.vid_adr_i[31:2], 2'b00};
    assign w_grant_len  = w_grant_clut ? bus.clut_len_i : bus.vid_len_i;
    assign w_grant_rem  = (w_grant_len == 8'd0) ? 8'd1 : w_grant_len;

    // An error on the same beat as an ack kills the ack.
    assign w_beat_ack = bus.wbm_ack_i & ~bus.wbm_err_i;
    assign w_last     = (r_rem == 8'd1);

    // Arbitration, burst sequencing and completion pulses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_starve    <= 4'd0;
            r_adr       <= 32'd0;
            r_rem       <= 8'd0;
            r_cyc       <= 1'b0;
            r_vid_gnt   <= 1'b0;
            r_clut_gnt  <= 1'b0;
            r_vid_done  <= 1'b0;
            r_clut_done <= 1'b0;
            r_vid_err   <= 1'b0;
            r_clut_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_BURST;
                        r_cyc      <= 1'b1;
                        r_vid_gnt  <= ~w_grant_clut;
                        r_clut_gnt <= w_grant_clut;
                        r_adr      <= w_grant_adr;
                        r_rem      <= w_grant_rem;
                        if (w_grant_clut)
                            r_starve <= 4'd0;
                        else if (bus.clut_req_i)
                            r_starve <= r_starve + 4'd1;
                    end
                end

                S_BURST: begin
                    if (bus.wbm_err_i) begin
                        r_state     <= S_DONE;
                        r_cyc       <= 1'b0;
                        r_vid_gnt   <= 1'b0;
                        r_clut_gnt  <= 1'b0;
                        r_vid_done  <= r_vid_gnt;
                        r_clut_done <= r_clut_gnt;
                        r_vid_err   <= r_vid_gnt;
                        r_clut_err  <= r_clut_gnt;
                    end else if (bus.wbm_ack_i) begin
                        r_adr <= r_adr + LP_STEP;
                        r_rem <= r_rem - 8'd1;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_cyc       <= 1'b0;
                            r_vid_gnt   <= 1'b0;
                            r_clut_gnt  <= 1'b0;
                            r_vid_done  <= r_vid_gnt;
                            r_clut_done <= r_clut_gnt;
                        end
                    end
                end

                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_vid_done  <= 1'b0;
                    r_clut_done <= 1'b0;
                    r_vid_err   <= 1'b0;
                    r_clut_err  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_cti_o = r_cyc ? (w_last ? 3'b111 : 3'b010) : 3'b000;
    assign bus.wbm_bte_o = 2'b00;

    assign bus.vid_gnt_o   = r_vid_gnt;
    assign bus.clut_gnt_o  = r_clut_gnt;
    // Beat acks pass straight through so the owner can capture wbm_dat_i.
    assign bus.vid_ack_o   = r_vid_gnt  & w_beat_ack;
    assign bus.clut_ack_o  = r_clut_gnt & w_beat_ack;
    assign bus.vid_done_o  = r_vid_done;
    assign bus.clut_done_o = r_clut_done;
    assign bus.vid_err_o   = r_vid_err;
    assign bus.clut_err_o  = r_clut_err;

endmodule

// File: tb/tb_vga_wbm_arbiter.sv
// Self-checking bench for vga_wbm_arbiter: directed scenarios plus a
// randomized request mix checked against a behavioural grant/burst model.
module tb_vga_wbm_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_starve = 0;   // model: vid grants while clut waited

    vga_wbm_arbiter_if bus();

    vga_wbm_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADR_STEP(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model of the arbitration rules; returns 1 when clut is granted.
    function automatic bit model_grant(input bit v, input bit c);
        bit g;
        g = c && (!v || m_starve == STARVE_LIMIT);
        if (g) m_starve = 0;
        else if (c) m_starve = m_starve + 1;
        return g;
    endfunction

    function automatic logic [31:0] all_outs();
        return {19'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_cti_o, bus.wbm_bte_o,
                bus.vid_gnt_o, bus.vid_ack_o, bus.vid_done_o, bus.vid_err_o,
                bus.clut_gnt_o, bus.clut_ack_o, bus.clut_done_o, bus.clut_err_o};
    endfunction

    // Wait for a burst, act as the Wishbone slave and check every beat,
    // the DONE cycle and the single-cycle done pulse.
    task automatic do_burst(input bit is_clut, input logic [31:0] adr, input int len,
                            input int err_beat, input int wait_pct, input bit drop,
                            input bit scramble);
        logic [31:0] exp_adr;
        int  eff, beat, waits;
        bit  got, ack, err, ended, err_hit, exp_ack;
        logic [2:0] exp_cti;
        eff = (len == 0) ? 1 : len;
        exp_adr = {adr[31:2], 2'b00};
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.wbm_cyc_o === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL burst_start got cyc=%b required cyc=1 within 20 cycles", bus.wbm_cyc_o);
            return;
        end
        if (scramble) begin
            if (is_clut) begin bus.clut_adr_i = $urandom; bus.clut_len_i = 8'($urandom); end
            else         begin bus.vid_adr_i  = $urandom; bus.vid_len_i  = 8'($urandom); end
        end
        beat = 0; waits = 0; ended = 0; err_hit = 0;
        while (!ended) begin
            exp_cti = (beat == eff - 1) ? 3'b111 : 3'b010;
            checks++;
            if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== exp_adr ||
                bus.wbm_cti_o !== exp_cti || bus.wbm_bte_o !== 2'b00 ||
                bus.vid_gnt_o !== !is_clut || bus.clut_gnt_o !== is_clut) begin
                errors++;
                $display("FAIL beat%0d got cyc=%b stb=%b adr=%h cti=%b gnt=%b%b required adr=%h cti=%b gnt=%b%b",
                         beat, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_cti_o,
                         bus.vid_gnt_o, bus.clut_gnt_o, exp_adr, exp_cti, !is_clut, is_clut);
            end
            err = (beat == err_beat);
            ack = err || (waits >= 3) || (int'($urandom_range(0, 99)) >= wait_pct);
            bus.wbm_ack_i = ack;
            bus.wbm_err_i = err;
            #1;
            exp_ack = ack && !err;
            checks++;
            if (bus.vid_ack_o !== (!is_clut && exp_ack) || bus.clut_ack_o !== (is_clut && exp_ack)) begin
                errors++;
                $display("FAIL beat_ack got vid=%b clut=%b required vid=%b clut=%b",
                         bus.vid_ack_o, bus.clut_ack_o, !is_clut && exp_ack, is_clut && exp_ack);
            end
            @(posedge clk); #1;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            if (err) begin
                ended = 1; err_hit = 1;
            end else if (ack) begin
                beat++; waits = 0; exp_adr = exp_adr + 32'd4;
                if (beat == eff) ended = 1;
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.vid_gnt_o !== 1'b0 ||
            bus.clut_gnt_o !== 1'b0 || bus.vid_done_o !== !is_clut || bus.clut_done_o !== is_clut ||
            bus.vid_err_o !== (!is_clut && err_hit) || bus.clut_err_o !== (is_clut && err_hit)) begin
            errors++;
            $display("FAIL done_cycle got cyc=%b gnt=%b%b done=%b%b err=%b%b required cyc=0 gnt=00 done=%b%b err=%b%b",
                     bus.wbm_cyc_o, bus.vid_gnt_o, bus.clut_gnt_o, bus.vid_done_o, bus.clut_done_o,
                     bus.vid_err_o, bus.clut_err_o, !is_clut, is_clut,
                     !is_clut && err_hit, is_clut && err_hit);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.vid_done_o !== 1'b0 || bus.clut_done_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL done_width got done=%b%b cyc=%b required done=00 cyc=0",
                     bus.vid_done_o, bus.clut_done_o, bus.wbm_cyc_o);
        end
        if (drop) begin
            if (is_clut) bus.clut_req_i = 1'b0;
            else         bus.vid_req_i  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== 32'd0 || bus.wbm_adr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h adr=%h required 0", all_outs(), bus.wbm_adr_o);
        end
        rst = 1'b0;
        m_starve = 0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 32'd0) begin
            errors++;
            $display("FAIL idle_no_req got %h required 0", all_outs());
        end
    endtask

    task automatic test_basic();
        bus.vid_adr_i = 32'h0000_1000; bus.vid_len_i = 8'd4; bus.vid_req_i = 1'b1;
        do_burst(model_grant(1, 0), 32'h0000_1000, 4, -1, 0, 1, 0);
    endtask

    task automatic test_len_zero();
        bus.clut_adr_i = 32'h0000_2003; bus.clut_len_i = 8'd0; bus.clut_req_i = 1'b1;
        do_burst(model_grant(0, 1), 32'h0000_2003, 0, -1, 0, 1, 0);
    endtask

    task automatic test_starvation();
        bit c;
        bus.vid_adr_i = 32'h0000_5000; bus.vid_len_i = 8'd1;
        bus.clut_adr_i = 32'h0000_6000; bus.clut_len_i = 8'd1;
        bus.vid_req_i = 1'b1; bus.clut_req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c = model_grant(1, 1);
            do_burst(c, c ? 32'h0000_6000 : 32'h0000_5000, 1, -1, 0, 0, 0);
        end
        bus.vid_req_i = 1'b0; bus.clut_req_i = 1'b0;
    endtask

    task automatic test_error();
        bus.vid_adr_i = 32'h0000_7000; bus.vid_len_i = 8'd3; bus.vid_req_i = 1'b1;
        do_burst(model_grant(1, 0), 32'h0000_7000, 3, 1, 0, 1, 0);
        bus.vid_adr_i = 32'h0000_7100; bus.vid_len_i = 8'd2; bus.vid_req_i = 1'b1;
        do_burst(model_grant(1, 0), 32'h0000_7100, 2, -1, 0, 1, 0);
    endtask

    task automatic test_wrap();
        bus.vid_adr_i = 32'hFFFF_FFF8; bus.vid_len_i = 8'd3; bus.vid_req_i = 1'b1;
        do_burst(model_grant(1, 0), 32'hFFFF_FFF8, 3, -1, 25, 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        bus.vid_adr_i = 32'h0000_4000; bus.vid_len_i = 8'd8; bus.vid_req_i = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.wbm_cyc_o === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_burst_start got cyc=0 required cyc=1");
        end
        bus.wbm_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.wbm_ack_i = 1'b0;
        checks++;
        if (bus.wbm_adr_o !== 32'h0000_4008 || bus.vid_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_progress got adr=%h gnt=%b required adr=00004008 gnt=1",
                     bus.wbm_adr_o, bus.vid_gnt_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 32'd0) begin
            errors++;
            $display("FAIL rst_async got %h required 0", all_outs());
        end
        m_starve = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.vid_done_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done got done=%b cyc=%b required 0", bus.vid_done_o, bus.wbm_cyc_o);
            end
        end
        rst = 1'b0;
        do_burst(model_grant(1, 0), 32'h0000_4000, 8, -1, 20, 1, 0);
    endtask

    task automatic test_random();
        bit vp, cp, c;
        logic [31:0] va, ca;
        int vl, cl, eb, len;
        vp = 0; cp = 0; va = 0; ca = 0; vl = 0; cl = 0;
        for (int i = 0; i < 24; i++) begin
            if (!vp && $urandom_range(0, 1) == 1) begin
                vp = 1; va = $urandom; vl = int'($urandom_range(0, 6));
                bus.vid_adr_i = va; bus.vid_len_i = 8'(vl); bus.vid_req_i = 1'b1;
            end
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1; ca = $urandom; cl = int'($urandom_range(0, 6));
                bus.clut_adr_i = ca; bus.clut_len_i = 8'(cl); bus.clut_req_i = 1'b1;
            end
            if (!vp && !cp) begin
                vp = 1; va = $urandom; vl = int'($urandom_range(0, 6));
                bus.vid_adr_i = va; bus.vid_len_i = 8'(vl); bus.vid_req_i = 1'b1;
            end
            c = model_grant(vp, cp);
            len = c ? cl : vl;
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, (len == 0) ? 0 : len - 1)) : -1;
            do_burst(c, c ? ca : va, len, eb, 30, 1, 1);
            if (c) cp = 0; else vp = 0;
        end
        bus.vid_req_i = 1'b0; bus.clut_req_i = 1'b0;
    endtask

    initial begin
        bus.vid_req_i = 1'b0;  bus.vid_adr_i = 32'd0;  bus.vid_len_i = 8'd0;
        bus.clut_req_i = 1'b0; bus.clut_adr_i = 32'd0; bus.clut_len_i = 8'd0;
        bus.wbm_ack_i = 1'b0;  bus.wbm_err_i = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_starvation();
        test_error();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
